// File: rtl/led_scan_ctrl_if.sv
// Bus between the CPU/ALU result path and the LED scan controller.
// The master side drives the captured word, flags and user controls;
// the slave side (the scan controller) returns the page select and
// the latched display data.
interface led_scan_ctrl_if;
    logic [31:0] LED_SCAN_data_xi;
    logic        LED_SCAN_overflow_flag_xi;
    logic        LED_SCAN_zero_flag_xi;
    logic        LED_SCAN_valid_xi;
    logic        LED_SCAN_mode_xi;
    logic [2:0]  LED_SCAN_SW_xi;
    logic        LED_SCAN_hold_xi;

    logic [2:0]  LED_SCAN_SW_xo;
    logic [31:0] LED_SCAN_data_xo;
    logic        LED_SCAN_overflow_flag_xo;
    logic        LED_SCAN_zero_flag_xo;
    logic        LED_SCAN_loaded_xo;
    logic        LED_SCAN_wrap_xo;

    modport master (
        output LED_SCAN_data_xi, LED_SCAN_overflow_flag_xi, LED_SCAN_zero_flag_xi,
               LED_SCAN_valid_xi, LED_SCAN_mode_xi, LED_SCAN_SW_xi, LED_SCAN_hold_xi,
        input  LED_SCAN_SW_xo, LED_SCAN_data_xo, LED_SCAN_overflow_flag_xo,
               LED_SCAN_zero_flag_xo, LED_SCAN_loaded_xo, LED_SCAN_wrap_xo
    );

    modport slave (
        input  LED_SCAN_data_xi, LED_SCAN_overflow_flag_xi, LED_SCAN_zero_flag_xi,
               LED_SCAN_valid_xi, LED_SCAN_mode_xi, LED_SCAN_SW_xi, LED_SCAN_hold_xi,
        output LED_SCAN_SW_xo, LED_SCAN_data_xo, LED_SCAN_overflow_flag_xo,
               LED_SCAN_zero_flag_xo, LED_SCAN_loaded_xo, LED_SCAN_wrap_xo
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// LED scan controller: captures a result word plus ALU flags and steps a
// 7-segment display through its pages, either automatically (one page per
// DWELL cycles, pausable with hold) or under switch control (manual mode).
// A capture always wins: it restarts the scan at page 0 and selects the
// mode currently requested.
module led_scan_ctrl #(
    parameter int DWELL = 16,
    parameter int PAGES = 5
) (
    input  logic             LED_SCAN_clk_xi,
    input  logic             LED_SCAN_rst_xi,
    led_scan_ctrl_if.slave   bus
);

    localparam int              CW        = $clog2(DWELL);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DWELL - 1);
    localparam logic [2:0]      PAGE_LAST = 3'(PAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_AUTO   = 2'd1,
        ST_MANUAL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      page_q, page_d;
    logic [2:0]      man_sw_q, man_sw_d;
    logic [31:0]     data_q, data_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            loaded_q, loaded_d;
    logic            wrap_q, wrap_d;
    logic [2:0]      sw_out;

    // Next-state logic: capture has priority over dwell expiry and mode switches.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        page_d   = page_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        loaded_d = loaded_q;
        wrap_d   = 1'b0;
        man_sw_d = ({29'd0, bus.LED_SCAN_SW_xi} >= 32'(PAGES)) ? PAGE_LAST
                                                                : bus.LED_SCAN_SW_xi;

        if (bus.LED_SCAN_valid_xi) begin
            data_d   = bus.LED_SCAN_data_xi;
            ovf_d    = bus.LED_SCAN_overflow_flag_xi;
            zero_d   = bus.LED_SCAN_zero_flag_xi;
            loaded_d = 1'b1;
            cnt_d    = '0;
            page_d   = '0;
            state_d  = bus.LED_SCAN_mode_xi ? ST_MANUAL : ST_AUTO;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d  = '0;
                    page_d = '0;
                end
                ST_AUTO: begin
                    if (bus.LED_SCAN_mode_xi) begin
                        state_d = ST_MANUAL;
                        cnt_d   = '0;
                        page_d  = '0;
                    end else if (!bus.LED_SCAN_hold_xi) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (page_q == PAGE_LAST) begin
                                page_d = '0;
                                wrap_d = 1'b1;
                            end else begin
                                page_d = page_q + 3'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_MANUAL: begin
                    cnt_d  = '0;
                    page_d = '0;
                    if (!bus.LED_SCAN_mode_xi) begin
                        state_d = ST_AUTO;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    page_d  = '0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge LED_SCAN_clk_xi or posedge LED_SCAN_rst_xi) begin
        if (LED_SCAN_rst_xi) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            page_q   <= '0;
            man_sw_q <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            loaded_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            page_q   <= page_d;
            man_sw_q <= man_sw_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            loaded_q <= loaded_d;
            wrap_q   <= wrap_d;
        end
    end

    // Page select shown on the display depends on which scan source is active.
    always_comb begin
        sw_out = 3'd0;
        unique case (state_q)
            ST_AUTO:   sw_out = page_q;
            ST_MANUAL: sw_out = man_sw_q;
            default:   sw_out = 3'd0;
        endcase
    end

    assign bus.LED_SCAN_SW_xo            = sw_out;
    assign bus.LED_SCAN_data_xo          = data_q;
    assign bus.LED_SCAN_overflow_flag_xo = ovf_q;
    assign bus.LED_SCAN_zero_flag_xo     = zero_q;
    assign bus.LED_SCAN_loaded_xo        = loaded_q;
    assign bus.LED_SCAN_wrap_xo          = wrap_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: directed scenarios followed by a randomized run,
// all compared against a page-arithmetic model of the scan behaviour.
module tb_led_scan_ctrl;

    localparam int DWELL = 16;
    localparam int PAGES = 5;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    led_scan_ctrl_if bus_if ();

    led_scan_ctrl #(.DWELL(DWELL), .PAGES(PAGES)) dut (
        .LED_SCAN_clk_xi (clk),
        .LED_SCAN_rst_xi (rst),
        .bus             (bus_if)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum {M_IDLE, M_AUTO, M_MANUAL} mstate_t;

    mstate_t     m_state;
    int          ticks;
    logic [31:0] m_data;
    logic        m_ovf;
    logic        m_zero;
    logic        m_loaded;
    logic        m_wrap;
    logic [2:0]  m_man;

    task automatic model_reset();
        m_state  = M_IDLE;
        ticks    = 0;
        m_data   = '0;
        m_ovf    = 1'b0;
        m_zero   = 1'b0;
        m_loaded = 1'b0;
        m_wrap   = 1'b0;
        m_man    = '0;
    endtask

    // Advances the model by one rising edge using the inputs currently applied.
    // In auto mode the page is derived from the count of running ticks.
    task automatic model_update();
        int sw_in;
        sw_in  = int'(bus_if.LED_SCAN_SW_xi);
        m_man  = 3'((sw_in >= PAGES) ? PAGES - 1 : sw_in);
        m_wrap = 1'b0;
        if (bus_if.LED_SCAN_valid_xi) begin
            m_data   = bus_if.LED_SCAN_data_xi;
            m_ovf    = bus_if.LED_SCAN_overflow_flag_xi;
            m_zero   = bus_if.LED_SCAN_zero_flag_xi;
            m_loaded = 1'b1;
            ticks    = 0;
            m_state  = bus_if.LED_SCAN_mode_xi ? M_MANUAL : M_AUTO;
        end else if (m_state == M_AUTO) begin
            if (bus_if.LED_SCAN_mode_xi) begin
                m_state = M_MANUAL;
                ticks   = 0;
            end else if (!bus_if.LED_SCAN_hold_xi) begin
                ticks++;
                if (ticks % (DWELL * PAGES) == 0) m_wrap = 1'b1;
            end
        end else if (m_state == M_MANUAL) begin
            if (!bus_if.LED_SCAN_mode_xi) begin
                m_state = M_AUTO;
                ticks   = 0;
            end
        end
    endtask

    function automatic logic [2:0] exp_sw();
        case (m_state)
            M_AUTO:   return 3'((ticks / DWELL) % PAGES);
            M_MANUAL: return m_man;
            default:  return 3'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input string name,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        chk(tag, "sw",     32'(bus_if.LED_SCAN_SW_xo),            32'(exp_sw()));
        chk(tag, "data",   bus_if.LED_SCAN_data_xo,               m_data);
        chk(tag, "ovf",    32'(bus_if.LED_SCAN_overflow_flag_xo), 32'(m_ovf));
        chk(tag, "zero",   32'(bus_if.LED_SCAN_zero_flag_xo),     32'(m_zero));
        chk(tag, "loaded", 32'(bus_if.LED_SCAN_loaded_xo),        32'(m_loaded));
        chk(tag, "wrap",   32'(bus_if.LED_SCAN_wrap_xo),          32'(m_wrap));
    endtask

    task automatic apply_stimulus(input logic valid, input logic mode, input logic hold,
                                  input logic [2:0] sw, input logic [31:0] data,
                                  input logic ovf, input logic zero);
        bus_if.LED_SCAN_valid_xi         = valid;
        bus_if.LED_SCAN_mode_xi          = mode;
        bus_if.LED_SCAN_hold_xi          = hold;
        bus_if.LED_SCAN_SW_xi            = sw;
        bus_if.LED_SCAN_data_xi          = data;
        bus_if.LED_SCAN_overflow_flag_xi = ovf;
        bus_if.LED_SCAN_zero_flag_xi     = zero;
    endtask

    // One rising edge, then the model follows and outputs are compared 1 unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_output(tag);
    endtask

    // Reset raised between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_output(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_output("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle ignores mode and switches until the first capture.
        apply_stimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step("idle_m1");
        apply_stimulus(1'b0, 1'b0, 1'b0, 3'd2, 32'hDEAD_BEEF, 1'b1, 1'b1);
        step("idle_m0");
        chk("idle", "sw", 32'(bus_if.LED_SCAN_SW_xo), 32'd0);

        // Capture all-ones, then a full auto scan with one wrap.
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step("cap1");
        chk("cap1", "data_const", bus_if.LED_SCAN_data_xo, 32'hFFFF_FFFF);
        chk("cap1", "loaded_const", 32'(bus_if.LED_SCAN_loaded_xo), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 80; i++) begin
            step("scan");
            if (i == 16) chk("scan16", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd1);
            if (i == 79) chk("scan79", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd4);
        end
        chk("wrap80", "wrap_const", 32'(bus_if.LED_SCAN_wrap_xo), 32'd1);
        chk("wrap80", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd0);
        step("post_wrap");
        chk("post_wrap", "wrap_const", 32'(bus_if.LED_SCAN_wrap_xo), 32'd0);

        // Hold on page 2 for 40 cycles, then finish the dwell.
        for (int i = 0; i < 36; i++) step("to_p2");
        bus_if.LED_SCAN_hold_xi = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step("hold");
            chk("hold", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd2);
        end
        bus_if.LED_SCAN_hold_xi = 1'b0;
        for (int i = 0; i < 10; i++) step("unhold");
        chk("unhold", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd2);
        step("unhold_adv");
        chk("unhold_adv", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd3);

        // Manual mode with clamping; data must not move.
        bus_if.LED_SCAN_mode_xi = 1'b1;
        bus_if.LED_SCAN_SW_xi   = 3'b111;
        step("man7");
        chk("man7", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd4);
        bus_if.LED_SCAN_SW_xi = 3'd1;
        step("man1");
        chk("man1", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd1);
        chk("man1", "data_const", bus_if.LED_SCAN_data_xo, 32'hFFFF_FFFF);

        // Capture exactly on the last dwell cycle of the last page.
        bus_if.LED_SCAN_mode_xi = 1'b0;
        step("to_auto");
        for (int i = 0; i < 79; i++) step("to_p4c15");
        apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234_5678, 1'b0, 1'b1);
        step("cap_expiry");
        chk("cap_expiry", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd0);
        chk("cap_expiry", "wrap_const", 32'(bus_if.LED_SCAN_wrap_xo), 32'd0);
        chk("cap_expiry", "data_const", bus_if.LED_SCAN_data_xo, 32'h1234_5678);
        bus_if.LED_SCAN_valid_xi = 1'b0;

        // Asynchronous reset mid-dwell on page 3, then stay idle.
        for (int i = 0; i < 55; i++) step("to_p3");
        async_reset("rst_mid");
        chk("rst_mid", "data_const", bus_if.LED_SCAN_data_xo, 32'd0);
        for (int i = 0; i < 100; i++) begin
            step("post_rst");
            chk("post_rst", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd0);
        end

        // First capture straight into manual mode.
        apply_stimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'hA5A5_0F0F, 1'b1, 1'b1);
        step("cap_manual");
        chk("cap_manual", "sw_const", 32'(bus_if.LED_SCAN_SW_xo), 32'd2);
        chk("cap_manual", "loaded_const", 32'(bus_if.LED_SCAN_loaded_xo), 32'd1);
        bus_if.LED_SCAN_valid_xi = 1'b0;

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(($urandom_range(15) == 0),
                           ($urandom_range(19) == 0) ? ~bus_if.LED_SCAN_mode_xi
                                                     : bus_if.LED_SCAN_mode_xi,
                           ($urandom_range(3) == 0),
                           3'($urandom_range(7)),
                           $urandom(),
                           1'($urandom_range(1)),
                           1'($urandom_range(1)));
            if ($urandom_range(299) == 0) async_reset("rand_rst");
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: LED_SCAN_CTRL

Interface
REQ-001 Parameter DWELL, default 16, SHALL set the clock cycles each page is displayed in auto mode (legal range 2..2^24).
REQ-002 Parameter PAGES, default 5, SHALL set the number of pages in the scan sequence: pages 0-3 are data bytes and page 4 is the flag page.
REQ-003 LED_SCAN_clk_xi SHALL be an input of width 1: the single clock, with all state updating on the rising edge.
REQ-004 LED_SCAN_rst_xi SHALL be an input of width 1: reset, asynchronous and active-high.
REQ-005 LED_SCAN_data_xi SHALL be an input of width 32: the CPU result word.
REQ-006 LED_SCAN_overflow_flag_xi and LED_SCAN_zero_flag_xi SHALL be inputs of width 1 each: the ALU flags.
REQ-007 LED_SCAN_valid_xi SHALL be an input of width 1: a strobe marking data and flags as valid for capture.
REQ-008 LED_SCAN_mode_xi SHALL be an input of width 1: 0 selects auto scan, 1 selects manual.
REQ-009 LED_SCAN_SW_xi SHALL be an input of width 3: the manual page select from the board switches.
REQ-010 LED_SCAN_hold_xi SHALL be an input of width 1: freezes the auto scan on the current page.
REQ-011 LED_SCAN_SW_xo SHALL be an output of width 3: the page select driving LED_DISPLAY_SW_xi.
REQ-012 LED_SCAN_data_xo SHALL be an output of width 32: the captured word driving LED_DISPLAY_data_xi.
REQ-013 LED_SCAN_overflow_flag_xo and LED_SCAN_zero_flag_xo SHALL be outputs of width 1 each: the captured flags.
REQ-014 LED_SCAN_loaded_xo SHALL be an output of width 1: high once any capture has occurred since reset.
REQ-015 LED_SCAN_wrap_xo SHALL be an output of width 1: a one-cycle pulse each time auto scan wraps from the last page to page 0.

Function
REQ-016 The block SHALL have states IDLE, AUTO and MANUAL, held in registered state.
REQ-017 In IDLE, SW_xo SHALL equal 0, the dwell counter SHALL stay at 0 and no wrap SHALL occur; this holds regardless of mode_xi.
REQ-018 valid_xi high at a rising edge SHALL latch data_xi and both flags into the output registers, visible the next cycle (1-cycle latency), and set loaded_xo to 1.
REQ-019 A capture SHALL, in the same edge, clear the dwell counter and page to 0, and move the state to AUTO if mode_xi=0 or to MANUAL if mode_xi=1.
REQ-020 While valid_xi is held high, the block SHALL capture on every cycle and the page SHALL stay at 0.
REQ-021 In AUTO with hold_xi=0, the dwell counter SHALL increment each cycle; at DWELL-1 it SHALL clear and the page SHALL advance by 1.
REQ-022 When the page advances from PAGES-1, it SHALL wrap to 0 and wrap_xo SHALL be high for exactly that one cycle.
REQ-023 In AUTO with hold_xi=1, the counter and page SHALL freeze, and wrap_xo SHALL be 0.
REQ-024 In AUTO, SW_xo SHALL equal the registered page.
REQ-025 In MANUAL, SW_xo SHALL equal SW_xi registered (1-cycle delay), clamped to PAGES-1 when SW_xi >= PAGES; the counter SHALL stay at 0 and wrap_xo SHALL be 0.
REQ-026 A change of mode_xi while loaded SHALL switch between AUTO and MANUAL on the next edge.
REQ-027 A switch into AUTO SHALL restart at page 0 with the counter at 0.
REQ-028 Simultaneous valid_xi and a dwell expiry SHALL resolve as capture priority: the page goes to 0 and no wrap pulse occurs.
REQ-029 Simultaneous valid_xi and a mode change SHALL capture and enter the state selected by the new mode_xi.
REQ-030 The captured data and flags SHALL change only on capture or reset.

Reset
REQ-031 Asserting rst_xi SHALL, asynchronously and at any point including mid-scan, force IDLE, and clear SW_xo, data_xo, both flags, loaded_xo, wrap_xo, the counter and the page to 0.
REQ-032 After rst_xi deasserts, the block SHALL leave IDLE only on a valid_xi capture.

Verification
REQ-033 Bench: reset, then valid_xi for 1 cycle with data 32'hFFFF_FFFF, ovf=1, zero=0, mode=0 -> data_xo=FFFF_FFFF and loaded=1 the next cycle; SW_xo steps 0,1,2,3,4 every 16 cycles; wrap pulses once at cycle 80 and SW_xo returns to 0.
REQ-034 Bench: in AUTO on page 2, assert hold for 40 cycles -> SW_xo stays 2 and wrap stays 0; release -> page 3 after the remaining dwell.
REQ-035 Bench: mode=1, SW_xi=3'b111 -> SW_xo=4 one cycle later; SW_xi=1 -> SW_xo=1; the data registers are unchanged.
REQ-036 Bench: valid_xi with data 32'h1234_5678 on the exact cycle the counter reaches 15 on page 4 -> page=0, no wrap pulse, data_xo=1234_5678.
REQ-037 Bench: assert rst_xi mid-dwell on page 3, between clock edges -> all outputs 0 immediately; SW_xo stays 0 with no valid_xi for 100 cycles.
REQ-038 Bench: valid_xi with no prior capture and mode=1, SW_xi=2 -> state MANUAL, SW_xo=2, loaded=1.
